// File: rtl/flipflop_pipe.sv
// DEPTH-stage enabled register pipeline with per-stage valid bits, flush and occupancy count.
// Define FLIPFLOP_PIPE_DATA_RST_EN to also clear the data registers on rst.
module flipflop_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           a,
  input  logic                       a_vld,
  input  logic                       flush,
  output logic [WIDTH-1:0]           y,
  output logic                       y_vld,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [OCC_W-1:0] r_occ;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [OCC_W-1:0] w_occ_nxt;
  logic             w_shift;

  // A shift happens only on a plain enabled edge; flush and reset both block it.
  assign w_shift = en && !flush && !rst;

  // Next valid vector and its population count, so occ is registered alongside the valids.
  always_comb begin
    w_vld_nxt = r_vld;
    w_occ_nxt = '0;
    if (flush) begin
      w_vld_nxt = '0;
    end else if (en) begin
      w_vld_nxt[0] = a_vld;
      for (int i = 1; i < int'(DEPTH); i++) begin
        w_vld_nxt[i] = r_vld[i-1];
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_vld_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_occ <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      r_occ <= w_occ_nxt;
    end
  end

`ifdef FLIPFLOP_PIPE_DATA_RST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
      end
    end else if (w_shift) begin
      r_data[0] <= a;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_data[i] <= r_data[i-1];
      end
    end
  end
`else
  // Data path carries no reset; bubbles still shift through as invalid slots.
  always_ff @(posedge clk) begin
    if (w_shift) begin
      r_data[0] <= a;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_data[i] <= r_data[i-1];
      end
    end
  end
`endif

  assign y     = r_data[DEPTH-1];
  assign y_vld = r_vld[DEPTH-1];
  assign occ   = r_occ;

endmodule

// File: tb/tb_flipflop_pipe.sv
// Scoreboard bench for flipflop_pipe: a DEPTH=3 instance and a DEPTH=1 instance share the stimulus.
module tb_flipflop_pipe;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned OW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          a_vld = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  y, y1;
  logic          y_vld, y1_vld;
  logic [OW-1:0] occ;
  logic [0:0]    occ1;

  typedef struct {
    logic [W-1:0] d;
    int           due;
  } item_t;

  item_t        q[$];
  int           ecnt = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  bit           mon_on = 1'b0;
  bit           last_rst = 1'b0;
  logic         exp_v1 = 1'b0;
  logic [W-1:0] exp_y1 = '0;

  always #5 clk = ~clk;

  flipflop_pipe #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .a_vld(a_vld), .flush(flush),
    .y(y), .y_vld(y_vld), .occ(occ)
  );

  flipflop_pipe #(.WIDTH(W), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .a(a), .a_vld(a_vld), .flush(flush),
    .y(y1), .y_vld(y1_vld), .occ(occ1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (enabled edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Drive one cycle of inputs, then record what the edge should have done.
  task automatic step(input logic r, input logic f, input logic e, input logic v,
                      input logic [W-1:0] d);
    @(negedge clk);
    rst = r; flush = f; en = e; a_vld = v; a = d;
    @(posedge clk);
    last_rst = r;
    if (r || f) begin
      q.delete();
      exp_v1 = 1'b0;
`ifdef FLIPFLOP_PIPE_DATA_RST_EN
      if (r) exp_y1 = '0;
`endif
    end else if (e) begin
      ecnt++;
      if (v) q.push_back('{d: d, due: ecnt + int'(D) - 1});
      exp_y1 = d;
      exp_v1 = v;
    end
    mon_on = 1'b1;
  endtask

  // Monitor: retire items that have shifted out, then compare what the DUT presents.
  always @(negedge clk) begin
    if (mon_on) begin
      logic exp_vld;
      while (q.size() > 0 && q[0].due < ecnt) void'(q.pop_front());
      exp_vld = (q.size() > 0) && (q[0].due == ecnt);
      chk("y_vld", 32'(y_vld), 32'(exp_vld));
      if (exp_vld) chk("y", 32'(y), 32'(q[0].d));
      chk("occ", 32'(occ), 32'(q.size()));
      chk("d1_y_vld", 32'(y1_vld), 32'(exp_v1));
      if (exp_v1) chk("d1_y", 32'(y1), 32'(exp_y1));
      chk("d1_occ", 32'(occ1), 32'(exp_v1));
`ifdef FLIPFLOP_PIPE_DATA_RST_EN
      if (last_rst) begin
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_d1_y", 32'(y1), 32'd0);
      end
`endif
    end
  end

  initial begin
    // Reset for two edges.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    // Streaming: 1110 for five cycles, then 0001 for five.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, (i < 5) ? 4'b1110 : 4'b0001);
    // Toggling data with one dropped valid.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, (i != 3), i[0] ? 4'b0001 : 4'b1110);
    // Bubbles, then refill to three valid stages.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    // Flush with en=1 and a valid 4'hF on the input.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    // Two valid stages, stall two cycles with a live input, then drain.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hC);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hC);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    // Reset, flush and enable together mid-stream.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h8);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'h9);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
